// File: rtl/debug_probe_capture_pkg.sv
// Shared constants for the debug probe capture buffer.
// Contents:
//   - APB register address map (8-bit address space)
//   - CTRL strobe and STATUS bit positions
//   - one-hot capture FSM state encoding
//   - post_clamp(): limits the programmed post-trigger count to the buffer depth
package debug_probe_capture_pkg;

    localparam logic [7:0] AddrCtrl     = 8'h00;
    localparam logic [7:0] AddrStatus   = 8'h01;
    localparam logic [7:0] AddrMaskLo   = 8'h02;
    localparam logic [7:0] AddrMaskHi   = 8'h03;
    localparam logic [7:0] AddrValLo    = 8'h04;
    localparam logic [7:0] AddrValHi    = 8'h05;
    localparam logic [7:0] AddrPostCnt  = 8'h06;
    localparam logic [7:0] AddrRdAddr   = 8'h07;
    localparam logic [7:0] AddrRdDataLo = 8'h08;
    localparam logic [7:0] AddrRdDataHi = 8'h09;
    localparam logic [7:0] AddrTrigPtr  = 8'h0A;

    localparam int unsigned CtrlArm   = 0;
    localparam int unsigned CtrlForce = 1;
    localparam int unsigned CtrlClear = 2;

    localparam int unsigned StatArmed     = 0;
    localparam int unsigned StatTriggered = 1;
    localparam int unsigned StatDone      = 2;
    localparam int unsigned StatWrapped   = 3;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StArmed = 4'b0010,
        StPost  = 4'b0100,
        StDone  = 4'b1000
    } cap_state_e;

    // At most DEPTH-1 samples can follow the trigger without overwriting it.
    function automatic logic [7:0] post_clamp(input logic [7:0] post_cnt,
                                              input int unsigned depth_log2);
        int unsigned max_cnt;
        max_cnt = (32'd1 << depth_log2) - 32'd1;
        return (int'(post_cnt) > int'(max_cnt)) ? 8'(max_cnt) : post_cnt;
    endfunction

endpackage

// File: rtl/probe_capture_ram.sv
// Simple dual-port RAM for the probe trace: one write port, one read port with a
// registered (1-cycle latency) output. No reset on the array or the read register
// so the tools can map it onto a uSRAM block.
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_re     - read enable; o_rdata holds its value when low
//   i_raddr  - read address
//   o_rdata  - read data, valid the cycle after i_re
module probe_capture_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [Depth];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_probe_capture.sv
// Debug probe capture buffer. Samples a 16-bit probe bus into a circular RAM while
// armed, stops a programmable number of samples after a trigger, and lets the CPU
// read the trace back over an 8-bit zero-wait-state APB3 slave.
// Ports:
//   clk16x      - sole clock (APB and probe synchronous)
//   reset       - synchronous, active-high
//   probe       - sampled data
//   ext_trig    - external level trigger, sampled each clock
//   apb3_sel / apb3_enable / apb3_write / apb3_addr / apb3_wdata - APB3 request
//   apb3_rdata  - read data, combinational, 0 when not selected
//   apb3_ready  - always 1
//   cap_int     - capture-done interrupt (level)
module debug_probe_capture
    import debug_probe_capture_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned PROBE_W    = 16
) (
    input  logic               clk16x,
    input  logic               reset,
    input  logic [PROBE_W-1:0] probe,
    input  logic               ext_trig,
    input  logic               apb3_sel,
    input  logic               apb3_enable,
    input  logic               apb3_write,
    input  logic [7:0]         apb3_addr,
    input  logic [7:0]         apb3_wdata,
    output logic [7:0]         apb3_rdata,
    output logic               apb3_ready,
    output logic               cap_int
);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    cap_state_e         r_state;
    cap_state_e         w_state_d;
    ptr_t               r_wr_ptr;
    ptr_t               r_trig_ptr;
    ptr_t               r_post;
    ptr_t               r_rd_addr;
    ptr_t               w_rd_addr_d;
    ptr_t               w_post_eff;
    logic               r_wrapped;
    logic               r_triggered;
    logic               r_load_pend;
    logic [PROBE_W-1:0] r_trig_mask;
    logic [PROBE_W-1:0] r_trig_val;
    logic [PROBE_W-1:0] r_hold;
    logic [7:0]         r_post_cnt;
    logic [PROBE_W-1:0] w_ram_rdata;
    logic               w_wr_stb;
    logic               w_rd_stb;
    logic               w_ctrl_wr;
    logic               w_arm;
    logic               w_clear;
    logic               w_force;
    logic               w_trig;
    logic               w_capture;
    logic               w_trig_hit;
    logic               w_rd_load;
    logic [7:0]         w_rdata;

    // APB decode
    assign w_wr_stb  = apb3_sel & apb3_enable & apb3_write;
    assign w_rd_stb  = apb3_sel & apb3_enable & ~apb3_write;
    assign w_ctrl_wr = w_wr_stb & (apb3_addr == AddrCtrl);
    assign w_clear   = w_ctrl_wr & apb3_wdata[CtrlClear];
    // CLEAR beats ARM when both are written together
    assign w_arm     = w_ctrl_wr & apb3_wdata[CtrlArm] & ~apb3_wdata[CtrlClear];
    assign w_force   = w_ctrl_wr & apb3_wdata[CtrlForce];

    assign w_post_eff = DEPTH_LOG2'(post_clamp(r_post_cnt, DEPTH_LOG2));

    assign w_trig = ((probe & r_trig_mask) == (r_trig_val & r_trig_mask)) | ext_trig | w_force;

    // A CTRL restart/clear takes priority over storing a sample that cycle
    assign w_capture  = ((r_state == StArmed) | (r_state == StPost)) & ~w_arm & ~w_clear;
    assign w_trig_hit = w_capture & (r_state == StArmed) & w_trig;

    // Capture FSM next state
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: w_state_d = StIdle;
            StArmed: begin
                if (w_trig_hit) begin
                    w_state_d = (w_post_eff == '0) ? StDone : StPost;
                end
            end
            StPost: begin
                if (r_post == ptr_t'(1)) begin
                    w_state_d = StDone;
                end
            end
            StDone: w_state_d = StDone;
            default: w_state_d = StIdle;
        endcase
        if (w_arm) begin
            w_state_d = StArmed;
        end
        if (w_clear) begin
            w_state_d = StIdle;
        end
    end

    // Readback address: written directly or bumped by a read of RD_DATA hi
    always_comb begin
        w_rd_addr_d = r_rd_addr;
        w_rd_load   = 1'b0;
        if (w_wr_stb && (apb3_addr == AddrRdAddr)) begin
            w_rd_addr_d = apb3_wdata[DEPTH_LOG2-1:0];
            w_rd_load   = 1'b1;
        end else if (w_rd_stb && (apb3_addr == AddrRdDataHi)) begin
            w_rd_addr_d = r_rd_addr + ptr_t'(1);
            w_rd_load   = 1'b1;
        end
    end

    always_ff @(posedge clk16x) begin
        if (reset) begin
            r_state     <= StIdle;
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_post      <= '0;
            r_rd_addr   <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_load_pend <= 1'b0;
            r_trig_mask <= '0;
            r_trig_val  <= '0;
            r_hold      <= '0;
            r_post_cnt  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_rd_addr   <= w_rd_addr_d;
            r_load_pend <= w_rd_load;

            // The RAM output lags the address by one cycle; latch it only once
            // the trace is complete so readback during capture stays stable.
            if (r_load_pend && (r_state == StDone)) begin
                r_hold <= w_ram_rdata;
            end

            if (w_wr_stb) begin
                unique case (apb3_addr)
                    AddrMaskLo:  r_trig_mask[7:0]  <= apb3_wdata;
                    AddrMaskHi:  r_trig_mask[15:8] <= apb3_wdata;
                    AddrValLo:   r_trig_val[7:0]   <= apb3_wdata;
                    AddrValHi:   r_trig_val[15:8]  <= apb3_wdata;
                    AddrPostCnt: r_post_cnt        <= apb3_wdata;
                    default: ;
                endcase
            end

            if (w_clear || w_arm) begin
                r_wr_ptr    <= '0;
                r_wrapped   <= 1'b0;
                r_triggered <= 1'b0;
                r_post      <= '0;
            end else if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
                if (r_wr_ptr == '1) begin
                    r_wrapped <= 1'b1;
                end
                if (w_trig_hit) begin
                    r_trig_ptr  <= r_wr_ptr;
                    r_triggered <= 1'b1;
                    r_post      <= w_post_eff;
                end else if (r_state == StPost) begin
                    r_post <= r_post - ptr_t'(1);
                end
            end
        end
    end

    probe_capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (PROBE_W)
    ) u_ram (
        .clk     (clk16x),
        .i_we    (w_capture),
        .i_waddr (r_wr_ptr),
        .i_wdata (probe),
        .i_re    (w_rd_load),
        .i_raddr (w_rd_addr_d),
        .o_rdata (w_ram_rdata)
    );

    // Read mux
    always_comb begin
        w_rdata = '0;
        if (apb3_sel) begin
            unique case (apb3_addr)
                AddrStatus: begin
                    w_rdata[StatArmed]     = (r_state == StArmed) | (r_state == StPost);
                    w_rdata[StatTriggered] = r_triggered;
                    w_rdata[StatDone]      = (r_state == StDone);
                    w_rdata[StatWrapped]   = r_wrapped;
                end
                AddrMaskLo:   w_rdata = r_trig_mask[7:0];
                AddrMaskHi:   w_rdata = r_trig_mask[15:8];
                AddrValLo:    w_rdata = r_trig_val[7:0];
                AddrValHi:    w_rdata = r_trig_val[15:8];
                AddrPostCnt:  w_rdata = r_post_cnt;
                AddrRdAddr:   w_rdata = 8'(r_rd_addr);
                AddrRdDataLo: w_rdata = r_hold[7:0];
                AddrRdDataHi: w_rdata = r_hold[15:8];
                AddrTrigPtr:  w_rdata = 8'(r_trig_ptr);
                default:      w_rdata = '0;
            endcase
        end
    end

    assign apb3_rdata = w_rdata;
    assign apb3_ready = 1'b1;
    assign cap_int    = (r_state == StDone);

endmodule

// File: tb/tb_debug_probe_capture.sv
module tb_debug_probe_capture;

    localparam int DepthLog2 = 6;
    localparam int Depth     = 64;
    localparam int HistLen   = 32768;

    logic        clk16x = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] probe = '0;
    logic        ext_trig = 1'b0;
    logic        apb3_sel = 1'b0;
    logic        apb3_enable = 1'b0;
    logic        apb3_write = 1'b0;
    logic [7:0]  apb3_addr = '0;
    logic [7:0]  apb3_wdata = '0;
    logic [7:0]  apb3_rdata;
    logic        apb3_ready;
    logic        cap_int;

    debug_probe_capture #(
        .DEPTH_LOG2 (DepthLog2),
        .PROBE_W    (16)
    ) dut (
        .clk16x      (clk16x),
        .reset       (reset),
        .probe       (probe),
        .ext_trig    (ext_trig),
        .apb3_sel    (apb3_sel),
        .apb3_enable (apb3_enable),
        .apb3_write  (apb3_write),
        .apb3_addr   (apb3_addr),
        .apb3_wdata  (apb3_wdata),
        .apb3_rdata  (apb3_rdata),
        .apb3_ready  (apb3_ready),
        .cap_int     (cap_int)
    );

    always #5 clk16x = ~clk16x;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Probe/ext_trig history indexed by clock edge number
    int          cyc = 0;
    logic [15:0] hist_p [HistLen];
    logic        hist_e [HistLen];

    always @(posedge clk16x) begin
        if (cyc < HistLen) begin
            hist_p[cyc] <= probe;
            hist_e[cyc] <= ext_trig;
        end
        cyc <= cyc + 1;
    end

    // Stimulus modes: 0 random probe + sparse random ext_trig,
    // 1 probe counts from 0x1230 on the first armed edge,
    // 2 random probe never 0xDEAD, single ext_trig pulse ext_off edges into capture
    int   mode = 0;
    int   arm_c = 1 << 30;
    int   ext_off = 0;
    logic ext_force = 1'b0;
    int   last_acc = 0;

    always @(negedge clk16x) begin
        case (mode)
            1: probe = 16'h1230 + 16'(cyc - arm_c - 1);
            2: begin
                probe = 16'($urandom);
                if (probe == 16'hDEAD) probe = 16'hBEEF;
            end
            default: probe = 16'($urandom);
        endcase
        ext_trig = ext_force | ((mode == 0) && ($urandom_range(31) == 0)) |
                   ((mode == 2) && (cyc == arm_c + 1 + ext_off));
    end

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk16x);
        apb3_sel = 1'b1; apb3_enable = 1'b0; apb3_write = 1'b1;
        apb3_addr = a; apb3_wdata = d;
        @(negedge clk16x);
        apb3_enable = 1'b1;
        last_acc = cyc;
        if (a == 8'h00 && d[0] && !d[2]) arm_c = cyc;
        @(negedge clk16x);
        apb3_sel = 1'b0; apb3_enable = 1'b0; apb3_write = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk16x);
        apb3_sel = 1'b1; apb3_enable = 1'b0; apb3_write = 1'b0; apb3_addr = a;
        @(negedge clk16x);
        apb3_enable = 1'b1;
        last_acc = cyc;
        #1 d = apb3_rdata;
        @(negedge clk16x);
        apb3_sel = 1'b0; apb3_enable = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    // Reference model: replays the recorded probe history from the first armed
    // edge, finds the trigger, and builds the expected buffer image.
    logic [15:0] exp_ram [Depth];
    logic        exp_valid [Depth];
    int          exp_trig_ptr, exp_k, exp_done_c;
    logic [7:0]  exp_status;

    task automatic model(input int arm, input int force_c, input logic [15:0] m,
                         input logic [15:0] v, input int post);
        int eff, ktrig, c;
        eff   = (post > Depth - 1) ? Depth - 1 : post;
        ktrig = -1;
        for (int i = 0; i < Depth; i++) exp_valid[i] = 1'b0;
        for (int k = 0; ktrig < 0 && arm + 1 + k < cyc && arm + 1 + k < HistLen; k++) begin
            c = arm + 1 + k;
            if (((hist_p[c] & m) == (v & m)) || hist_e[c] || c == force_c) ktrig = k;
        end
        if (ktrig < 0) begin
            exp_k = -1; exp_trig_ptr = -1; exp_done_c = -1; exp_status = 8'hFF;
            return;
        end
        exp_k = ktrig + eff;
        for (int k = 0; k <= exp_k; k++) begin
            exp_ram[k % Depth]   = hist_p[arm + 1 + k];
            exp_valid[k % Depth] = 1'b1;
        end
        exp_trig_ptr = ktrig % Depth;
        exp_done_c   = arm + 2 + exp_k;
        exp_status   = 8'h06 | ((exp_k >= Depth - 1) ? 8'h08 : 8'h00);
    endtask

    task automatic wait_done(output int done_c);
        int n;
        n = 0;
        while (cap_int !== 1'b1 && n < 2000) begin
            @(negedge clk16x);
            n++;
        end
        done_c = (cap_int === 1'b1) ? cyc : -1;
    endtask

    task automatic check_buffer(input string tag);
        logic [7:0] lo, hi;
        int bad;
        bad = 0;
        apb_write(8'h07, 8'h00);
        for (int i = 0; i < Depth; i++) begin
            apb_read(8'h08, lo);
            apb_read(8'h09, hi);
            if (exp_valid[i] && ({hi, lo} !== exp_ram[i])) bad++;
        end
        check({tag, "_buf_bad"}, bad, 0);
        check_reg({tag, "_rdaddr_wrap"}, 8'h07, 8'h00);
    endtask

    // Program, arm, optionally force, wait for done, and compare against the model.
    task automatic run_capture(input string tag, input logic [15:0] m, input logic [15:0] v,
                               input logic [7:0] post, input int force_after);
        int force_c, done_c;
        force_c = -1;
        apb_write(8'h02, m[7:0]);
        apb_write(8'h03, m[15:8]);
        apb_write(8'h04, v[7:0]);
        apb_write(8'h05, v[15:8]);
        apb_write(8'h06, post);
        apb_write(8'h00, 8'h01);
        if (force_after >= 0) begin
            repeat (force_after) @(negedge clk16x);
            apb_write(8'h00, 8'h02);
            force_c = last_acc;
        end
        wait_done(done_c);
        model(arm_c, force_c, m, v, int'(post));
        check({tag, "_done_cyc"}, done_c, exp_done_c);
        check_reg({tag, "_status"}, 8'h01, exp_status);
        check_reg({tag, "_trig_ptr"}, 8'h0A, 8'(exp_trig_ptr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lo, hi;

        // Reset with a capture armed beforehand
        repeat (3) @(negedge clk16x);
        reset = 1'b0;
        apb_write(8'h02, 8'hFF);
        apb_write(8'h00, 8'h01);
        repeat (2) @(negedge clk16x);
        reset = 1'b1;
        repeat (2) @(negedge clk16x);
        reset = 1'b0;
        check("rst_cap_int", cap_int, 1'b0);
        check("rst_rdata_unsel", apb3_rdata, 8'h00);
        check("ready", apb3_ready, 1'b1);
        check_reg("rst_status", 8'h01, 8'h00);
        check_reg("rst_trig_ptr", 8'h0A, 8'h00);
        check_reg("rst_mask_lo", 8'h02, 8'h00);
        check_reg("rst_rd_addr", 8'h07, 8'h00);

        // Register access
        apb_write(8'h03, 8'hA5);
        check_reg("mask_hi_rw", 8'h03, 8'hA5);
        apb_write(8'h06, 8'h3C);
        check_reg("post_cnt_rw", 8'h06, 8'h3C);
        apb_write(8'h07, 8'hFF);
        check_reg("rd_addr_trunc", 8'h07, 8'h3F);
        apb_write(8'h0B, 8'h77);
        check_reg("undef_addr", 8'h0B, 8'h00);
        check_reg("ctrl_reads0", 8'h00, 8'h00);

        // Counting probe, value trigger on 0x1234 with 4 post samples
        mode = 1;
        run_capture("count", 16'hFFFF, 16'h1234, 8'd4, -1);
        check("count_cap_int", cap_int, 1'b1);
        check("count_trig_ptr_const", exp_trig_ptr, 4);
        apb_write(8'h07, 8'h04);
        for (int i = 0; i < 5; i++) begin
            apb_read(8'h08, lo);
            apb_read(9'h09, hi);
            check($sformatf("count_rd%0d", i), {hi, lo}, 16'h1234 + 16'(i));
        end
        check_reg("count_rdaddr_inc", 8'h07, 8'h09);
        check_buffer("count");

        // Mask 0 and POST_CNT 0: trigger on first armed edge, done next cycle
        mode = 0;
        run_capture("mask0", 16'h0000, 16'h0000, 8'd0, -1);
        check("mask0_trig_ptr_const", exp_trig_ptr, 0);

        // Clamped post count with wrap
        mode = 2;
        ext_off = 100;
        run_capture("clamp", 16'hFFFF, 16'hDEAD, 8'd200, -1);
        check("clamp_status_const", exp_status, 8'h0E);
        check_buffer("clamp");

        // FORCE_TRIG with an unmatchable value trigger
        ext_off = 100000;
        run_capture("force", 16'hFFFF, 16'hDEAD, 8'd10, 20);
        check_buffer("force");

        // Randomised captures
        mode = 0;
        for (int t = 0; t < 6; t++) begin
            logic [15:0] m, v;
            logic [7:0]  p;
            m = 16'($urandom & $urandom & $urandom);
            v = 16'($urandom);
            p = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(40));
            run_capture($sformatf("rnd%0d", t), m, v, p, -1);
            check_buffer($sformatf("rnd%0d", t));
        end

        // CLEAR mid-POST
        apb_write(8'h02, 8'h00);
        apb_write(8'h03, 8'h00);
        apb_write(8'h06, 8'd50);
        apb_write(8'h00, 8'h01);
        apb_write(8'h00, 8'h04);
        check("clr_cap_int", cap_int, 1'b0);
        check_reg("clr_status", 8'h01, 8'h00);
        repeat (60) @(negedge clk16x);
        check("clr_stays_idle", cap_int, 1'b0);
        check_reg("clr_status_late", 8'h01, 8'h00);

        // ARM together with CLEAR stays idle
        apb_write(8'h00, 8'h05);
        repeat (5) @(negedge clk16x);
        check_reg("armclr_status", 8'h01, 8'h00);
        check("armclr_cap_int", cap_int, 1'b0);

        // ext_trig pulse while idle is ignored
        mode = 1;
        ext_force = 1'b1;
        repeat (3) @(negedge clk16x);
        ext_force = 1'b0;
        repeat (3) @(negedge clk16x);
        check_reg("idle_ext_status", 8'h01, 8'h00);
        check("idle_ext_cap_int", cap_int, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
